// File: rtl/segments_persist.sv
// rtl/segments_persist.sv - per-segment fading brightness renderer with vblank sweep FSM
// Sweep FSM updates a brightness RAM once per frame; the video path reads it with 2-cycle latency.
module segments_persist #(
    parameter int MAX_X_SEGMENT = 9,
    parameter int MAX_Y_SEGMENT = 16,
    parameter int MAX_Z_SEGMENT = 4,
    parameter int ALPHA_WIDTH   = 4,
    parameter int RISE_STEP     = 15,
    parameter int FALL_STEP     = 5,
    parameter int PERSIST_EN    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT],
    input  logic                     vblank_int,
    input  logic                     has_segment,
    input  logic [9:0]               segment_id,
    output logic [ALPHA_WIDTH-1:0]   segment_alpha,
    output logic                     segment_en,
    output logic                     sweep_busy
);

    localparam int N         = MAX_X_SEGMENT * MAX_Y_SEGMENT * MAX_Z_SEGMENT;
    localparam int ADDR_W    = (N > 1) ? $clog2(N) : 1;
    localparam int X_W       = (MAX_X_SEGMENT > 1) ? $clog2(MAX_X_SEGMENT) : 1;
    localparam int Y_W       = (MAX_Y_SEGMENT > 1) ? $clog2(MAX_Y_SEGMENT) : 1;
    localparam int Z_W       = (MAX_Z_SEGMENT > 1) ? $clog2(MAX_Z_SEGMENT) : 1;
    localparam int ALPHA_MAX = (1 << ALPHA_WIDTH) - 1;
    localparam bit PERSIST   = (PERSIST_EN != 0);

    localparam logic [ADDR_W-1:0]      LAST_IDX   = ADDR_W'(N - 1);
    localparam logic [ALPHA_WIDTH-1:0] ALPHA_FULL = ALPHA_WIDTH'(ALPHA_MAX);
    localparam logic [ALPHA_WIDTH:0]   RISE_W     = (ALPHA_WIDTH + 1)'(RISE_STEP);
    localparam logic [ALPHA_WIDTH:0]   FALL_W     = (ALPHA_WIDTH + 1)'(FALL_STEP);
    localparam logic [ALPHA_WIDTH:0]   MAX_W      = (ALPHA_WIDTH + 1)'(ALPHA_MAX);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t                   state, state_next;
    logic [ADDR_W-1:0]        sweep_idx, sweep_idx_next;
    logic                     vblank_q;
    logic                     vblank_rise;

    logic                     b_we;
    logic [ALPHA_WIDTH-1:0]   b_wdata;
    logic [ALPHA_WIDTH-1:0]   b_q;
    logic [ALPHA_WIDTH-1:0]   a_q;

    logic [X_W-1:0]           sweep_x;
    logic [Y_W-1:0]           sweep_y;
    logic [Z_W-1:0]           sweep_z;
    logic                     sweep_on;
    logic [ALPHA_WIDTH:0]     rise_sum;
    logic [ALPHA_WIDTH-1:0]   alpha_new;

    logic [3:0]               id_line;
    logic [3:0]               id_col;
    logic [1:0]               id_row;
    logic                     id_in_range;
    logic [X_W-1:0]           id_x;
    logic [Y_W-1:0]           id_y;
    logic [Z_W-1:0]           id_z;
    logic [ADDR_W-1:0]        id_idx;

    logic                     s1_valid;
    logic                     s1_in_range;
    logic                     s1_on;
    logic [ALPHA_WIDTH-1:0]   alpha_next;

    assign vblank_rise = vblank_int && !vblank_q;
    assign sweep_busy  = (state != ST_IDLE);

    // Sweep index to matrix coordinates: idx = (x*Y + y)*Z + z
    always_comb begin
        sweep_x  = X_W'(int'(sweep_idx) / (MAX_Y_SEGMENT * MAX_Z_SEGMENT));
        sweep_y  = Y_W'((int'(sweep_idx) / MAX_Z_SEGMENT) % MAX_Y_SEGMENT);
        sweep_z  = Z_W'(int'(sweep_idx) % MAX_Z_SEGMENT);
        sweep_on = segments[sweep_x][sweep_y][sweep_z];
    end

    // Wider arithmetic so a saturating rise never wraps
    always_comb begin
        rise_sum = {1'b0, b_q} + RISE_W;
        if (sweep_on) begin
            alpha_new = (rise_sum > MAX_W) ? ALPHA_FULL : rise_sum[ALPHA_WIDTH-1:0];
        end else begin
            alpha_new = ({1'b0, b_q} > FALL_W) ? (b_q - FALL_W[ALPHA_WIDTH-1:0]) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            sweep_idx <= '0;
            vblank_q  <= 1'b0;
        end else begin
            state     <= state_next;
            sweep_idx <= sweep_idx_next;
            vblank_q  <= vblank_int;
        end
    end

    always_comb begin
        state_next     = state;
        sweep_idx_next = sweep_idx;
        b_we           = 1'b0;
        b_wdata        = '0;
        case (state)
            ST_CLEAR: begin
                b_we = 1'b1;
                if (sweep_idx == LAST_IDX) begin
                    state_next     = ST_IDLE;
                    sweep_idx_next = '0;
                end else begin
                    sweep_idx_next = sweep_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                if (PERSIST && vblank_rise) begin
                    state_next     = ST_READ;
                    sweep_idx_next = '0;
                end
            end
            ST_READ: begin
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                b_we    = 1'b1;
                b_wdata = alpha_new;
                if (sweep_idx == LAST_IDX) begin
                    state_next     = ST_IDLE;
                    sweep_idx_next = '0;
                end else begin
                    state_next     = ST_READ;
                    sweep_idx_next = sweep_idx + 1'b1;
                end
            end
            default: begin
                state_next     = ST_CLEAR;
                sweep_idx_next = '0;
            end
        endcase
    end

    // Out-of-range ids are folded to entry 0 so neither the RAM nor the matrix is indexed past its end
    always_comb begin
        id_line     = segment_id[9:6];
        id_col      = segment_id[5:2];
        id_row      = segment_id[1:0];
        id_in_range = (int'(id_line) < MAX_X_SEGMENT) &&
                      (int'(id_col)  < MAX_Y_SEGMENT) &&
                      (int'(id_row)  < MAX_Z_SEGMENT);
        id_x = '0;
        id_y = '0;
        id_z = '0;
        if (id_in_range) begin
            id_x = X_W'(id_line);
            id_y = Y_W'(id_col);
            id_z = Z_W'(id_row);
        end
        id_idx = ADDR_W'((int'(id_x) * MAX_Y_SEGMENT + int'(id_y)) * MAX_Z_SEGMENT + int'(id_z));
    end

    generate
        if (PERSIST) begin : g_ram
            logic [ALPHA_WIDTH-1:0] mem [N];

            // Port A (video) and port B (sweep) reads are read-before-write on collision
            always_ff @(posedge clk) begin
                if (b_we) begin
                    mem[sweep_idx] <= b_wdata;
                end
                a_q <= mem[id_idx];
                b_q <= mem[sweep_idx];
            end
        end else begin : g_bypass
            assign a_q = '0;
            assign b_q = '0;
        end
    endgenerate

    always_comb begin
        alpha_next = '0;
        if (PERSIST) begin
            if (s1_valid && s1_in_range) begin
                alpha_next = a_q;
            end
        end else if (s1_on) begin
            alpha_next = ALPHA_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_in_range   <= 1'b0;
            s1_on         <= 1'b0;
            segment_alpha <= '0;
            segment_en    <= 1'b0;
        end else begin
            s1_valid      <= has_segment;
            s1_in_range   <= id_in_range;
            s1_on         <= segments[id_x][id_y][id_z] & id_in_range & has_segment;
            segment_alpha <= alpha_next;
            segment_en    <= (alpha_next != '0);
        end
    end

endmodule

// File: tb/tb_segments_persist.sv
// tb/tb_segments_persist.sv - randomized self-checking bench for segments_persist
// Reference model keeps one integer brightness per segment and applies the frame rules directly.
module tb_segments_persist;

    localparam int NX = 9;
    localparam int NY = 16;
    localparam int NZ = 4;
    localparam int N  = NX * NY * NZ;

    logic       clk;
    logic       reset;
    logic [3:0] segments [NX][NY];
    logic       vblank_int;
    logic       has_segment;
    logic [9:0] segment_id;
    logic [3:0] segment_alpha;
    logic       segment_en;
    logic       sweep_busy;
    logic [3:0] bp_alpha;
    logic       bp_en;
    logic       bp_busy;

    int alpha_m [N];
    int n_checks = 0;
    int n_fail   = 0;
    int len;

    segments_persist dut (
        .clk          (clk),
        .reset        (reset),
        .segments     (segments),
        .vblank_int   (vblank_int),
        .has_segment  (has_segment),
        .segment_id   (segment_id),
        .segment_alpha(segment_alpha),
        .segment_en   (segment_en),
        .sweep_busy   (sweep_busy)
    );

    segments_persist #(.PERSIST_EN(0)) dut_bp (
        .clk          (clk),
        .reset        (reset),
        .segments     (segments),
        .vblank_int   (vblank_int),
        .has_segment  (has_segment),
        .segment_id   (segment_id),
        .segment_alpha(bp_alpha),
        .segment_en   (bp_en),
        .sweep_busy   (bp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_frame();
        for (int i = 0; i < N; i++) begin
            int x = i / (NY * NZ);
            int y = (i / NZ) % NY;
            int z = i % NZ;
            if (segments[x][y][z]) alpha_m[i] = (alpha_m[i] + 15 > 15) ? 15 : alpha_m[i] + 15;
            else                   alpha_m[i] = (alpha_m[i] > 5) ? alpha_m[i] - 5 : 0;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) alpha_m[i] = 0;
    endfunction

    task automatic count_busy(output int n);
        n = 0;
        while (sweep_busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // forced >= 0 overrides the model value for the main instance
    task automatic lookup(input int ln, input int col, input int row, input int forced);
        int exp, exp_bp;
        bit inr;
        inr    = (ln < NX);
        exp    = inr ? alpha_m[(ln * NY + col) * NZ + row] : 0;
        if (forced >= 0) exp = forced;
        exp_bp = (inr && segments[ln][col][row]) ? 15 : 0;
        has_segment = 1'b1;
        segment_id  = {4'(ln), 4'(col), 2'(row)};
        @(negedge clk);
        has_segment = 1'b0;
        segment_id  = 10'($urandom);
        check("alpha_early", segment_alpha, 0);
        @(negedge clk);
        check("alpha", segment_alpha, exp);
        check("en", segment_en, (exp != 0) ? 1 : 0);
        check("bp_alpha", bp_alpha, exp_bp);
        check("bp_en", bp_en, (exp_bp != 0) ? 1 : 0);
    endtask

    task automatic random_lookups(input int count);
        for (int k = 0; k < count; k++) begin
            lookup($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 3), -1);
        end
    endtask

    // glitch: vblank falls and rises again mid-sweep, which must not restart or queue
    task automatic run_sweep(input bit glitch);
        int n;
        vblank_int = 1'b1;
        @(negedge clk);
        check("bp_no_sweep", bp_busy, 0);
        n = 0;
        while (sweep_busy && n < 5000) begin
            n++;
            if (n == 40) vblank_int = 1'b0;
            if (glitch && n == 300) vblank_int = 1'b1;
            if (glitch && n == 320) vblank_int = 1'b0;
            @(negedge clk);
        end
        vblank_int = 1'b0;
        check("sweep_len", n, 2 * N);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_after_sweep", sweep_busy, 0);
        end
        model_frame();
    endtask

    initial begin
        int fade [4] = '{10, 5, 0, 0};
        reset       = 1'b1;
        vblank_int  = 1'b0;
        has_segment = 1'b0;
        segment_id  = '0;
        for (int x = 0; x < NX; x++) for (int y = 0; y < NY; y++) segments[x][y] = '0;
        model_clear();

        @(negedge clk);
        check("rst_alpha", segment_alpha, 0);
        check("rst_en", segment_en, 0);
        check("rst_busy", sweep_busy, 1);
        check("rst_bp_busy", bp_busy, 1);
        reset = 1'b0;
        count_busy(len);
        check("clear_len", len, N);
        check("bp_idle", bp_busy, 0);
        random_lookups(6);

        segments[3][5][2] = 1'b1;
        run_sweep(1'b0);
        lookup(3, 5, 2, 15);
        random_lookups(6);

        segments[3][5][2] = 1'b0;
        for (int e = 0; e < 4; e++) begin
            run_sweep(1'b0);
            lookup(3, 5, 2, fade[e]);
        end

        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < NX; x++) for (int y = 0; y < NY; y++) segments[x][y] = 4'($urandom);
            run_sweep(r == 1);
            random_lookups(10);
        end
        lookup(12, 5, 2, 0);
        lookup(15, 15, 3, 0);

        vblank_int = 1'b1;
        @(negedge clk);
        len = 0;
        while (sweep_busy && len < 300) begin
            len++;
            if (len == 20) vblank_int = 1'b0;
            @(negedge clk);
        end
        vblank_int = 1'b0;
        check("busy_before_abort", sweep_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_busy(len);
        check("clear_after_abort", len, N);
        model_clear();
        random_lookups(8);
        run_sweep(1'b1);
        random_lookups(8);

        for (int x = 0; x < NX; x++) for (int y = 0; y < NY; y++) segments[x][y] = '0;
        segments[0][0][0] = 1'b1;
        lookup(0, 0, 0, -1);
        segments[0][0][0] = 1'b0;
        lookup(0, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
